ysyx_22041211_mem_arbiter: RTL and testbench

Two-requester memory arbiter for the RV32 core. It shares one physical memory port between instruction fetch (IFU) and load/store (LSU) so that fetch and data access both leave the DPI `pmem_read_task`/`pmem_write_task` path and use a single handshaked bus. The arbiter sits between the counter/ifetch and wb/EXE memory paths on one side and the memory model or SRAM on the other. It serialises accesses with one outstanding transaction at a time.

---
 rtl/ysyx_22041211_mem_arbiter_pkg.sv | 29 ++
 rtl/ysyx_22041211_mem_arbiter_if.sv | 62 ++++++
 rtl/ysyx_22041211_mem_arbiter_pick.sv | 53 +++++
 rtl/ysyx_22041211_mem_arbiter.sv | 207 ++++++++++++++++++++
 tb/tb_ysyx_22041211_mem_arbiter.sv | 309 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ysyx_22041211_mem_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// ysyx_22041211_arb_pkg
// Shared types and constants for the IFU/LSU memory arbiter.
//   arb_state_e : FSM state encoding (IDLE, ISSUE, WAIT, RESP)
//   GNT_*       : owner encoding, also used as the picker's one-hot result
//                 (bit 0 = IFU, bit 1 = LSU)
//   MASK_FULL   : byte mask applied to every instruction fetch
// ----------------------------------------------------------------------------
package ysyx_22041211_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ISSUE = 2'b01,
        WAIT  = 2'b10,
        RESP  = 2'b11
    } arb_state_e;

    localparam logic [1:0] GNT_NONE  = 2'b00;
    localparam logic [1:0] GNT_IF    = 2'b01;
    localparam logic [1:0] GNT_LS    = 2'b10;

    localparam logic [3:0] MASK_FULL = 4'b1111;

    // True when a grant/pick value names exactly one requester.
    function automatic logic grant_is_valid(input logic [1:0] gnt);
        return (gnt == GNT_IF) || (gnt == GNT_LS);
    endfunction

endpackage

// File: rtl/ysyx_22041211_mem_arbiter_if.sv
// ----------------------------------------------------------------------------
// ysyx_22041211_mem_arbiter_if
// Bundles the three buses around the arbiter:
//   if_*  : instruction-fetch read request / response
//   ls_*  : load/store request / response
//   mem_* : the single shared memory port
//   grant_o : current owner of the memory port
// Modports:
//   master : the arbiter's view (drives readies, responses and the mem request)
//   slave  : the environment's view (requesters and memory model)
// ----------------------------------------------------------------------------
interface ysyx_22041211_mem_arbiter_if #(
    parameter int DATA_LEN = 32,
    parameter int ADDR_LEN = 32
);
    logic                if_req_valid;
    logic [ADDR_LEN-1:0] if_addr;
    logic                if_req_ready;
    logic                if_rsp_valid;
    logic [DATA_LEN-1:0] if_rsp_data;

    logic                ls_req_valid;
    logic [ADDR_LEN-1:0] ls_addr;
    logic                ls_wen;
    logic [DATA_LEN-1:0] ls_wdata;
    logic [3:0]          ls_wmask;
    logic                ls_req_ready;
    logic                ls_rsp_valid;
    logic [DATA_LEN-1:0] ls_rsp_data;

    logic                mem_req_valid;
    logic [ADDR_LEN-1:0] mem_addr;
    logic                mem_wen;
    logic [DATA_LEN-1:0] mem_wdata;
    logic [3:0]          mem_wmask;
    logic                mem_req_ready;
    logic                mem_rsp_valid;
    logic [DATA_LEN-1:0] mem_rsp_data;

    logic [1:0]          grant_o;

    modport master (
        input  if_req_valid, if_addr,
        output if_req_ready, if_rsp_valid, if_rsp_data,
        input  ls_req_valid, ls_addr, ls_wen, ls_wdata, ls_wmask,
        output ls_req_ready, ls_rsp_valid, ls_rsp_data,
        output mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask,
        input  mem_req_ready, mem_rsp_valid, mem_rsp_data,
        output grant_o
    );

    modport slave (
        output if_req_valid, if_addr,
        input  if_req_ready, if_rsp_valid, if_rsp_data,
        output ls_req_valid, ls_addr, ls_wen, ls_wdata, ls_wmask,
        input  ls_req_ready, ls_rsp_valid, ls_rsp_data,
        input  mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask,
        output mem_req_ready, mem_rsp_valid, mem_rsp_data,
        input  grant_o
    );

endinterface

// File: rtl/ysyx_22041211_mem_arbiter_pick.sv
// ----------------------------------------------------------------------------
// ysyx_22041211_arb_pick
// Combinational winner selection between IFU and LSU.
//   if_req_valid, ls_req_valid : pending requests
//   last_grant                 : previous winner (only meaningful in
//                                round-robin builds)
//   pick_oh                    : one-hot winner, GNT_IF / GNT_LS / GNT_NONE
// Configuration macro: YSYX_22041211_ARB_RR_EN
//   defined   -> round-robin on ties (the requester not granted last wins)
//   undefined -> fixed priority, LSU over IFU (last_grant ignored)
// ----------------------------------------------------------------------------
module ysyx_22041211_arb_pick
    import ysyx_22041211_arb_pkg::*;
(
    input  logic       if_req_valid,
    input  logic       ls_req_valid,
    input  logic [1:0] last_grant,
    output logic [1:0] pick_oh
);

`ifdef YSYX_22041211_ARB_RR_EN
    // Round-robin: a tie alternates away from the previous winner.
    always_comb begin
        pick_oh = GNT_NONE;
        if (if_req_valid && ls_req_valid) begin
            pick_oh = (last_grant == GNT_LS) ? GNT_IF : GNT_LS;
        end else if (ls_req_valid) begin
            pick_oh = GNT_LS;
        end else if (if_req_valid) begin
            pick_oh = GNT_IF;
        end else begin
            pick_oh = GNT_NONE;
        end
    end
`else
    // The load/store belongs to the instruction in flight, so it goes first.
    logic unused_last_grant_s;
    assign unused_last_grant_s = ^last_grant;

    // Fixed priority: LSU beats IFU.
    always_comb begin
        pick_oh = GNT_NONE;
        if (ls_req_valid) begin
            pick_oh = GNT_LS;
        end else if (if_req_valid) begin
            pick_oh = GNT_IF;
        end else begin
            pick_oh = GNT_NONE;
        end
    end
`endif

endmodule

// File: rtl/ysyx_22041211_mem_arbiter.sv
// ----------------------------------------------------------------------------
// ysyx_22041211_mem_arbiter
// Shares one memory port between instruction fetch and load/store with a
// single outstanding transaction: IDLE (accept) -> ISSUE (mem request held
// until mem_req_ready) -> WAIT (capture response) -> RESP (one-cycle pulse).
// Ports:
//   clk : clock, all state changes on the rising edge
//   rst : synchronous active-low reset
//   bus : ysyx_22041211_mem_arbiter_if.master (IFU, LSU, memory, grant_o)
// Configuration macro: YSYX_22041211_ARB_RR_EN adds a last-grant register
// that makes ties round-robin; without it ties go to the LSU.
// ----------------------------------------------------------------------------
module ysyx_22041211_mem_arbiter
    import ysyx_22041211_arb_pkg::*;
#(
    parameter int DATA_LEN = 32,
    parameter int ADDR_LEN = 32
) (
    input  logic                            clk,
    input  logic                            rst,
    ysyx_22041211_mem_arbiter_if.master     bus
);

    arb_state_e          state_r;
    arb_state_e          state_s;

    logic [1:0]          pick_oh_s;
    logic [1:0]          last_grant_s;
    logic [1:0]          grant_r;
    logic                accept_s;

    logic [ADDR_LEN-1:0] addr_r;
    logic                wen_r;
    logic [DATA_LEN-1:0] wdata_r;
    logic [3:0]          wmask_r;
    logic [DATA_LEN-1:0] if_rsp_data_r;
    logic [DATA_LEN-1:0] ls_rsp_data_r;

    logic                if_req_ready_s;
    logic                ls_req_ready_s;
    logic                mem_req_valid_s;
    logic                if_rsp_valid_s;
    logic                ls_rsp_valid_s;

    ysyx_22041211_arb_pick u_pick (
        .if_req_valid (bus.if_req_valid),
        .ls_req_valid (bus.ls_req_valid),
        .last_grant   (last_grant_s),
        .pick_oh      (pick_oh_s)
    );

`ifdef YSYX_22041211_ARB_RR_EN
    logic [1:0] last_grant_r;

    // Remember the most recent winner so the next tie goes the other way.
    always_ff @(posedge clk) begin
        if (!rst) begin
            last_grant_r <= GNT_IF;
        end else if (accept_s) begin
            last_grant_r <= pick_oh_s;
        end else begin
            last_grant_r <= last_grant_r;
        end
    end

    assign last_grant_s = last_grant_r;
`else
    assign last_grant_s = GNT_NONE;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic; a response seen outside WAIT never moves the FSM.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (grant_is_valid(pick_oh_s)) begin
                    state_s = ISSUE;
                end else begin
                    state_s = IDLE;
                end
            end
            ISSUE: begin
                if (bus.mem_req_ready) begin
                    state_s = WAIT;
                end else begin
                    state_s = ISSUE;
                end
            end
            WAIT: begin
                if (bus.mem_rsp_valid) begin
                    state_s = RESP;
                end else begin
                    state_s = WAIT;
                end
            end
            RESP: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Output decode; readies are masked while reset is held so nothing
    // looks accepted during reset.
    always_comb begin
        accept_s        = 1'b0;
        if_req_ready_s  = 1'b0;
        ls_req_ready_s  = 1'b0;
        mem_req_valid_s = 1'b0;
        if_rsp_valid_s  = 1'b0;
        ls_rsp_valid_s  = 1'b0;
        case (state_r)
            IDLE: begin
                accept_s       = rst && grant_is_valid(pick_oh_s);
                if_req_ready_s = rst && (pick_oh_s == GNT_IF);
                ls_req_ready_s = rst && (pick_oh_s == GNT_LS);
            end
            ISSUE: begin
                mem_req_valid_s = 1'b1;
            end
            WAIT: begin
                mem_req_valid_s = 1'b0;
            end
            RESP: begin
                if_rsp_valid_s = (grant_r == GNT_IF);
                ls_rsp_valid_s = (grant_r == GNT_LS);
            end
            default: begin
                accept_s = 1'b0;
            end
        endcase
    end

    // Request latch, owner tracking and response capture.
    always_ff @(posedge clk) begin
        if (!rst) begin
            grant_r       <= GNT_NONE;
            addr_r        <= {ADDR_LEN{1'b0}};
            wen_r         <= 1'b0;
            wdata_r       <= {DATA_LEN{1'b0}};
            wmask_r       <= 4'b0000;
            if_rsp_data_r <= {DATA_LEN{1'b0}};
            ls_rsp_data_r <= {DATA_LEN{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (pick_oh_s == GNT_LS) begin
                        grant_r <= GNT_LS;
                        addr_r  <= bus.ls_addr;
                        wen_r   <= bus.ls_wen;
                        wdata_r <= bus.ls_wdata;
                        wmask_r <= bus.ls_wmask;
                    end else if (pick_oh_s == GNT_IF) begin
                        // Fetches are always full-word reads.
                        grant_r <= GNT_IF;
                        addr_r  <= bus.if_addr;
                        wen_r   <= 1'b0;
                        wdata_r <= {DATA_LEN{1'b0}};
                        wmask_r <= MASK_FULL;
                    end else begin
                        grant_r <= GNT_NONE;
                    end
                end
                WAIT: begin
                    if (bus.mem_rsp_valid && (grant_r == GNT_LS)) begin
                        ls_rsp_data_r <= bus.mem_rsp_data;
                    end else if (bus.mem_rsp_valid && (grant_r == GNT_IF)) begin
                        if_rsp_data_r <= bus.mem_rsp_data;
                    end else begin
                        ls_rsp_data_r <= ls_rsp_data_r;
                    end
                end
                RESP: begin
                    grant_r <= GNT_NONE;
                end
                default: begin
                    grant_r <= grant_r;
                end
            endcase
        end
    end

    assign bus.if_req_ready  = if_req_ready_s;
    assign bus.ls_req_ready  = ls_req_ready_s;
    assign bus.if_rsp_valid  = if_rsp_valid_s;
    assign bus.ls_rsp_valid  = ls_rsp_valid_s;
    assign bus.if_rsp_data   = if_rsp_data_r;
    assign bus.ls_rsp_data   = ls_rsp_data_r;
    assign bus.mem_req_valid = mem_req_valid_s;
    assign bus.mem_addr      = addr_r;
    assign bus.mem_wen       = wen_r;
    assign bus.mem_wdata     = wdata_r;
    assign bus.mem_wmask     = wmask_r;
    assign bus.grant_o       = grant_r;

endmodule

// File: tb/tb_ysyx_22041211_mem_arbiter.sv
// ----------------------------------------------------------------------------
// Directed bench for ysyx_22041211_mem_arbiter. Inputs change 1 time unit
// after the rising edge, outputs are checked 1 unit later.
// ----------------------------------------------------------------------------
module tb_ysyx_22041211_mem_arbiter;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    ysyx_22041211_mem_arbiter_if #(.DATA_LEN(32), .ADDR_LEN(32)) bus ();

    ysyx_22041211_mem_arbiter #(.DATA_LEN(32), .ADDR_LEN(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_if_ready"},  32'(bus.if_req_ready),  32'h0);
        chk({tag, "_ls_ready"},  32'(bus.ls_req_ready),  32'h0);
        chk({tag, "_if_rspv"},   32'(bus.if_rsp_valid),  32'h0);
        chk({tag, "_ls_rspv"},   32'(bus.ls_rsp_valid),  32'h0);
        chk({tag, "_mem_valid"}, 32'(bus.mem_req_valid), 32'h0);
        chk({tag, "_mem_wen"},   32'(bus.mem_wen),       32'h0);
        chk({tag, "_mem_addr"},  bus.mem_addr,           32'h0);
        chk({tag, "_mem_wdata"}, bus.mem_wdata,          32'h0);
        chk({tag, "_mem_wmask"}, 32'(bus.mem_wmask),     32'h0);
        chk({tag, "_if_data"},   bus.if_rsp_data,        32'h0);
        chk({tag, "_ls_data"},   bus.ls_rsp_data,        32'h0);
        chk({tag, "_grant"},     32'(bus.grant_o),       32'h0);
    endtask

`ifdef YSYX_22041211_ARB_RR_EN
    // One zero-wait transaction starting in IDLE; requesters keep their valids.
    task automatic rr_serve(input string tag, input logic [1:0] exp_gnt);
        bus.mem_req_ready = 1'b1;
        settle();
        chk({tag, "_ready"}, 32'({bus.ls_req_ready, bus.if_req_ready}), 32'(exp_gnt));
        cyc();
        settle();
        chk({tag, "_grant"}, 32'(bus.grant_o), 32'(exp_gnt));
        cyc();
        bus.mem_req_ready = 1'b0;
        bus.mem_rsp_valid = 1'b1;
        bus.mem_rsp_data  = 32'h0000_0000;
        cyc();
        bus.mem_rsp_valid = 1'b0;
        cyc();
    endtask
`endif

    initial begin
        #100000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        checks   = 0;
        failures = 0;

        // Reset held for two edges with an IFU fetch already pending.
        rst               = 1'b0;
        bus.if_req_valid  = 1'b1;
        bus.if_addr       = 32'h8000_0000;
        bus.ls_req_valid  = 1'b0;
        bus.ls_addr       = 32'h0;
        bus.ls_wen        = 1'b0;
        bus.ls_wdata      = 32'h0;
        bus.ls_wmask      = 4'b0000;
        bus.mem_req_ready = 1'b0;
        bus.mem_rsp_valid = 1'b0;
        bus.mem_rsp_data  = 32'h0;
        cyc();
        cyc();
        settle();
        chk_all_zero("rst");

        rst = 1'b1;
        settle();
        chk("rel_if_ready", 32'(bus.if_req_ready), 32'h1);
        chk("rel_ls_ready", 32'(bus.ls_req_ready), 32'h0);
        cyc();
        bus.if_req_valid  = 1'b0;
        bus.mem_req_ready = 1'b1;
        settle();
        chk("rel_mem_addr",  bus.mem_addr,           32'h8000_0000);
        chk("rel_mem_valid", 32'(bus.mem_req_valid), 32'h1);
        chk("rel_grant",     32'(bus.grant_o),       32'h1);
        chk("rel_wmask",     32'(bus.mem_wmask),     32'hF);
        cyc();
        bus.mem_req_ready = 1'b0;
        bus.mem_rsp_valid = 1'b1;
        bus.mem_rsp_data  = 32'h1111_1111;
        cyc();
        bus.mem_rsp_valid = 1'b0;
        settle();
        chk("rel_rspv", 32'(bus.if_rsp_valid), 32'h1);
        chk("rel_data", bus.if_rsp_data,       32'h1111_1111);
        cyc();

        // IFU read, zero-wait memory.
        bus.if_req_valid  = 1'b1;
        bus.if_addr       = 32'h8000_0004;
        bus.mem_req_ready = 1'b1;
        settle();
        chk("if_c0_ready", 32'(bus.if_req_ready), 32'h1);
        cyc();
        bus.if_req_valid = 1'b0;
        settle();
        chk("if_c1_valid", 32'(bus.mem_req_valid), 32'h1);
        chk("if_c1_addr",  bus.mem_addr,           32'h8000_0004);
        chk("if_c1_rspv",  32'(bus.if_rsp_valid),  32'h0);
        cyc();
        bus.mem_req_ready = 1'b0;
        bus.mem_rsp_valid = 1'b1;
        bus.mem_rsp_data  = 32'h0010_0093;
        settle();
        chk("if_c2_valid", 32'(bus.mem_req_valid), 32'h0);
        chk("if_c2_rspv",  32'(bus.if_rsp_valid),  32'h0);
        cyc();
        bus.mem_rsp_valid = 1'b0;
        settle();
        chk("if_c3_rspv", 32'(bus.if_rsp_valid), 32'h1);
        chk("if_c3_data", bus.if_rsp_data,       32'h0010_0093);
        cyc();
        settle();
        chk("if_c4_rspv",  32'(bus.if_rsp_valid), 32'h0);
        chk("if_c4_hold",  bus.if_rsp_data,       32'h0010_0093);
        chk("if_c4_grant", 32'(bus.grant_o),      32'h0);

        // LSU write.
        bus.ls_req_valid  = 1'b1;
        bus.ls_wen        = 1'b1;
        bus.ls_addr       = 32'h8000_1000;
        bus.ls_wdata      = 32'hDEAD_BEEF;
        bus.ls_wmask      = 4'b0011;
        bus.mem_req_ready = 1'b1;
        settle();
        chk("wr_ls_ready", 32'(bus.ls_req_ready), 32'h1);
        chk("wr_if_ready", 32'(bus.if_req_ready), 32'h0);
        cyc();
        bus.ls_req_valid = 1'b0;
        settle();
        chk("wr_valid", 32'(bus.mem_req_valid), 32'h1);
        chk("wr_wen",   32'(bus.mem_wen),       32'h1);
        chk("wr_addr",  bus.mem_addr,           32'h8000_1000);
        chk("wr_wdata", bus.mem_wdata,          32'hDEAD_BEEF);
        chk("wr_wmask", 32'(bus.mem_wmask),     32'h3);
        chk("wr_grant", 32'(bus.grant_o),       32'h2);
        cyc();
        bus.mem_req_ready = 1'b0;
        bus.mem_rsp_valid = 1'b1;
        bus.mem_rsp_data  = 32'h0000_0000;
        cyc();
        bus.mem_rsp_valid = 1'b0;
        settle();
        chk("wr_ls_rspv", 32'(bus.ls_rsp_valid), 32'h1);
        chk("wr_if_rspv", 32'(bus.if_rsp_valid), 32'h0);
        cyc();
        settle();
        chk("wr_ls_rspv_end", 32'(bus.ls_rsp_valid), 32'h0);
        chk("wr_if_hold",     bus.if_rsp_data,        32'h0010_0093);
        bus.ls_wen = 1'b0;

`ifndef YSYX_22041211_ARB_RR_EN
        // Tie under fixed priority: LSU first, IFU at the next IDLE.
        bus.if_req_valid  = 1'b1;
        bus.if_addr       = 32'h8000_0008;
        bus.ls_req_valid  = 1'b1;
        bus.ls_addr       = 32'h8000_2000;
        bus.mem_req_ready = 1'b1;
        settle();
        chk("tie_ls_ready", 32'(bus.ls_req_ready), 32'h1);
        chk("tie_if_ready", 32'(bus.if_req_ready), 32'h0);
        cyc();
        bus.ls_req_valid = 1'b0;
        settle();
        chk("tie_grant_ls", 32'(bus.grant_o),      32'h2);
        chk("tie_ls_addr",  bus.mem_addr,          32'h8000_2000);
        chk("tie_if_wait",  32'(bus.if_req_ready), 32'h0);
        cyc();
        bus.mem_rsp_valid = 1'b1;
        bus.mem_rsp_data  = 32'h1234_5678;
        cyc();
        bus.mem_rsp_valid = 1'b0;
        settle();
        chk("tie_ls_rspv", 32'(bus.ls_rsp_valid), 32'h1);
        chk("tie_ls_data", bus.ls_rsp_data,       32'h1234_5678);
        chk("tie_resp_if", 32'(bus.if_req_ready), 32'h0);
        cyc();
        settle();
        chk("tie_grant_none", 32'(bus.grant_o),      32'h0);
        chk("tie_if_ready2",  32'(bus.if_req_ready), 32'h1);
        cyc();
        bus.if_req_valid = 1'b0;
        settle();
        chk("tie_grant_if", 32'(bus.grant_o), 32'h1);
        chk("tie_if_addr",  bus.mem_addr,     32'h8000_0008);
        cyc();
        bus.mem_rsp_valid = 1'b1;
        bus.mem_rsp_data  = 32'hAAAA_5555;
        cyc();
        bus.mem_rsp_valid = 1'b0;
        settle();
        chk("tie_if_rspv", 32'(bus.if_rsp_valid), 32'h1);
        chk("tie_if_data", bus.if_rsp_data,       32'hAAAA_5555);
        cyc();
`endif

        // Backpressure: five cycles of mem_req_ready=0 with a stray response.
        bus.if_req_valid  = 1'b1;
        bus.if_addr       = 32'h8000_000C;
        bus.mem_req_ready = 1'b0;
        settle();
        chk("bp_ready", 32'(bus.if_req_ready), 32'h1);
        cyc();
        bus.if_req_valid = 1'b0;
        bus.if_addr      = 32'h0;
        for (int i = 0; i < 5; i++) begin
            bus.mem_rsp_valid = (i == 2);
            bus.mem_rsp_data  = 32'hBADB_AD00;
            settle();
            chk("bp_valid", 32'(bus.mem_req_valid), 32'h1);
            chk("bp_addr",  bus.mem_addr,           32'h8000_000C);
            chk("bp_wmask", 32'(bus.mem_wmask),     32'hF);
            chk("bp_rspv",  32'(bus.if_rsp_valid),  32'h0);
            cyc();
        end
        bus.mem_rsp_valid = 1'b0;
        bus.mem_req_ready = 1'b1;
        settle();
        chk("bp_c6_valid", 32'(bus.mem_req_valid), 32'h1);
        cyc();
        bus.mem_req_ready = 1'b0;
        bus.mem_rsp_valid = 1'b1;
        bus.mem_rsp_data  = 32'h0BAD_F00D;
        settle();
        chk("bp_c7_rspv", 32'(bus.if_rsp_valid), 32'h0);
        cyc();
        bus.mem_rsp_valid = 1'b0;
        settle();
        chk("bp_c8_rspv", 32'(bus.if_rsp_valid), 32'h1);
        chk("bp_c8_data", bus.if_rsp_data,       32'h0BAD_F00D);
        cyc();
        settle();
        chk("bp_c9_rspv", 32'(bus.if_rsp_valid), 32'h0);

        // Reset while waiting for an LSU read: response discarded.
        bus.ls_req_valid  = 1'b1;
        bus.ls_addr       = 32'h8000_3000;
        bus.mem_req_ready = 1'b1;
        cyc();
        bus.ls_req_valid = 1'b0;
        cyc();
        rst               = 1'b0;
        bus.mem_req_ready = 1'b0;
        bus.mem_rsp_valid = 1'b1;
        bus.mem_rsp_data  = 32'h7777_7777;
        cyc();
        rst               = 1'b1;
        bus.mem_rsp_valid = 1'b0;
        settle();
        chk_all_zero("midrst");
        cyc();
        settle();
        chk("midrst_no_rsp", 32'(bus.ls_rsp_valid), 32'h0);

`ifdef YSYX_22041211_ARB_RR_EN
        // Round-robin: prime last grant with an LSU, then three ties.
        bus.ls_req_valid = 1'b1;
        bus.ls_addr      = 32'h8000_4000;
        rr_serve("rr_pre", 2'b10);
        bus.if_req_valid = 1'b1;
        bus.if_addr      = 32'h8000_0010;
        rr_serve("rr_tie1", 2'b01);
        rr_serve("rr_tie2", 2'b10);
        rr_serve("rr_tie3", 2'b01);
        bus.if_req_valid = 1'b0;
        bus.ls_req_valid = 1'b0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
